rev_share_ctrl: RTL and testbench
=================================

REV_SHARE_CTRL -- requirements
Module: rev_share_ctrl

Interface
REQ-001 Parameter CNT_W, default 8: width of completed-operation counter; legal range 4..16.
REQ-002 Port clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port rst  input  1  synchronous, active-high reset.
REQ-004 Port req0_valid  input  1  requester 0 has an operation pending.
REQ-005 Port req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 Port req0_data  input  16  requester 0 operand.
REQ-007 Port req0_rev  input  1  requester 0 reverse enable (1 = bit-reverse, 0 = pass-through).
REQ-008 Ports req1_valid, req1_ready, req1_data, req1_rev SHALL mirror REQ-004..REQ-007 for requester 1.
REQ-009 Port out_valid  output  1  result slot holds a valid result.
REQ-010 Port out_ready  input  1  consumer accepts result this cycle.
REQ-011 Port out_data  output  16  registered result.
REQ-012 Port out_id  output  1  index of the requester that produced out_data.
REQ-013 Port done_cnt  output  CNT_W  count of results consumed.

Function
REQ-014 The block SHALL share one bit-reversal datapath between two requesters through a one-entry registered result slot.
REQ-015 FSM states: IDLE (slot empty) and HOLD (slot full); IDLE->HOLD on accept; HOLD->IDLE on out_ready with no accept; HOLD->HOLD on out_ready with accept, or on !out_ready.
REQ-016 Accept-enable SHALL be: state==IDLE, or state==HOLD and out_ready==1.
REQ-017 At most one reqN_ready SHALL be high per cycle; reqN_ready is combinational and high only when accept-enable, reqN_valid==1, and requester N wins arbitration.
REQ-018 Result latency SHALL be 1 cycle: operand accepted at edge k appears on out_data/out_id with out_valid=1 after edge k.
REQ-019 out_data SHALL equal reqN_data bit-reversed (bit i <- bit 15-i) when reqN_rev==1, else reqN_data unchanged.
REQ-020 out_data/out_id SHALL remain stable while out_valid==1 and out_ready==0.
REQ-021 Back-to-back throughput SHALL be one result per cycle when out_ready is held high.
REQ-022 done_cnt SHALL increment on each cycle with out_valid && out_ready and saturate at 2^CNT_W-1 (no wrap).
REQ-023 reqN_valid without reqN_ready SHALL have no effect on state; requesters hold data until ready.

Reset
REQ-024 On rst: state=IDLE, out_valid=0, out_data=16'h0000, out_id=0, done_cnt=0, round-robin pointer=1 (requester 0 wins first contention).
REQ-025 rst SHALL take precedence over any simultaneous accept or drain; reqN_ready SHALL be 0 during rst; an in-flight slot result SHALL be discarded.

Configuration
REQ-026 Macro REV_RR_EN defined: round-robin arbitration; on contention the requester not most recently granted wins; pointer updates only on accept.
REQ-027 Macro REV_RR_EN undefined: fixed priority, requester 0 always wins contention; no pointer register.

Structure
REQ-028 Shared package/include rev_pkg SHALL hold state encodings ST_IDLE/ST_HOLD and requester ID constants REQ_ID0/REQ_ID1.
REQ-029 The datapath SHALL be one instance of reverse_16b fed by the arbitration mux; no other sub-module.

Verification
REQ-030 After rst, req0 valid data=16'h0001 rev=1, out_ready=1 -> next cycle out_valid=1, out_data=16'h8000, out_id=0, done_cnt=1 cycle after.
REQ-031 req1 data=16'h00F0 rev=0 -> out_data=16'h00F0, out_id=1.
REQ-032 Both valid continuously 4 cycles, out_ready=1, REV_RR_EN defined -> out_id sequence 0,1,0,1; undefined -> 0,0,0,0 with req1_ready never high.
REQ-033 Slot full, out_ready=0 for 3 cycles with req0 valid -> req0_ready=0, out_data stable; out_ready=1 -> drain and accept same cycle, out_valid stays 1.
REQ-034 CNT_W=4, 20 consumed results -> done_cnt=4'hF, holds.
REQ-035 rst asserted while HOLD with out_ready=0 -> next cycle out_valid=0, out_data=0, done_cnt=0, subsequent contention granted to req0.

Source files
------------

// File: rtl/rev_pkg.sv
// Shared definitions for rev_share_ctrl: slot FSM state encodings and
// requester identifiers.
package rev_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic REQ_ID0 = 1'b0;
  localparam logic REQ_ID1 = 1'b1;

  localparam int unsigned DATA_W = 16;

endpackage : rev_pkg

// File: rtl/rev_share_ctrl_reverse.sv
// reverse_16b: optional bit reversal of a 16-bit operand (bit i <- bit 15-i),
// the single datapath shared by both requesters.
module reverse_16b
  import rev_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  input  logic              rev_i,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] flipped;

  always_comb begin
    flipped = '0;
    for (int i = 0; i < DATA_W; i++) begin
      flipped[i] = data_i[DATA_W-1-i];
    end
  end

  assign data_o = rev_i ? flipped : data_i;

endmodule : reverse_16b

// File: rtl/rev_share_ctrl.sv
// Two requesters share one bit-reversal datapath through a one-entry result slot.
// Define REV_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module rev_share_ctrl
  import rev_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req0_rev,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_data,
  input  logic              req1_rev,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_id,
  output logic [CNT_W-1:0]  done_cnt
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_id_q, out_id_d;
  logic [CNT_W-1:0]  done_cnt_q, done_cnt_d;

  logic              accept_en;
  logic              accept;
  logic              win_id;
  logic [DATA_W-1:0] sel_data;
  logic              sel_rev;
  logic [DATA_W-1:0] rev_data;

`ifdef REV_RR_EN
  // Remembers the last granted requester; contention goes to the other one.
  logic last_grant_q, last_grant_d;

  always_comb begin
    win_id = REQ_ID0;
    if (req0_valid && req1_valid) begin
      win_id = ~last_grant_q;
    end else if (req1_valid) begin
      win_id = REQ_ID1;
    end
  end
`else
  always_comb begin
    win_id = (req1_valid && !req0_valid) ? REQ_ID1 : REQ_ID0;
  end
`endif

  assign accept_en  = (state_q == ST_IDLE) || out_ready;
  assign req0_ready = !rst && accept_en && req0_valid && (win_id == REQ_ID0);
  assign req1_ready = !rst && accept_en && req1_valid && (win_id == REQ_ID1);
  assign accept     = req0_ready || req1_ready;

  assign sel_data = (win_id == REQ_ID1) ? req1_data : req0_data;
  assign sel_rev  = (win_id == REQ_ID1) ? req1_rev  : req0_rev;

  reverse_16b u_reverse (
    .data_i (sel_data),
    .rev_i  (sel_rev),
    .data_o (rev_data)
  );

  always_comb begin
    state_d    = state_q;
    out_data_d = out_data_q;
    out_id_d   = out_id_q;
    done_cnt_d = done_cnt_q;

    unique case (state_q)
      ST_IDLE: if (accept) state_d = ST_HOLD;
      ST_HOLD: if (out_ready && !accept) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      out_data_d = rev_data;
      out_id_d   = win_id;
    end

    // Consumed results are counted, sticking at all-ones instead of wrapping.
    if (out_valid && out_ready && (done_cnt_q != {CNT_W{1'b1}})) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
  end

`ifdef REV_RR_EN
  always_comb begin
    last_grant_d = accept ? win_id : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= REQ_ID1;
    else     last_grant_q <= last_grant_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      out_data_q <= '0;
      out_id_q   <= REQ_ID0;
      done_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_id_q   <= out_id_d;
      done_cnt_q <= done_cnt_d;
    end
  end

  assign out_valid = (state_q == ST_HOLD);
  assign out_data  = out_data_q;
  assign out_id    = out_id_q;
  assign done_cnt  = done_cnt_q;

endmodule : rev_share_ctrl

// File: tb/tb_rev_share_ctrl.sv
// Self-checking bench for rev_share_ctrl: directed scenarios followed by
// random traffic, all compared against a transaction-level slot model.
module tb_rev_share_ctrl;

  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              req0_valid, req0_ready, req0_rev;
  logic [15:0]       req0_data;
  logic              req1_valid, req1_ready, req1_rev;
  logic [15:0]       req1_data;
  logic              out_valid, out_ready, out_id;
  logic [15:0]       out_data;
  logic [CNT_W-1:0]  done_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model of the result slot, kept as plain values
  bit        m_full = 0;
  bit [15:0] m_data = '0;
  bit        m_id   = 0;
  int        m_cnt  = 0;
  bit        m_last = 1;
  bit        took0, took1;

  always #5 clk = ~clk;

  rev_share_ctrl #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_rev   (req0_rev),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_rev   (req1_rev),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_id     (out_id),
    .done_cnt   (done_cnt)
  );

  function automatic bit [15:0] expectResult(input bit [15:0] d, input bit r);
    bit [15:0] flipped;
    flipped = {<<{d}};
    return r ? flipped : d;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit v0, input bit [15:0] d0, input bit rv0,
                               input bit v1, input bit [15:0] d1, input bit rv1,
                               input bit ordy);
    rst        = r;
    req0_valid = v0;
    req0_data  = d0;
    req0_rev   = rv0;
    req1_valid = v1;
    req1_data  = d1;
    req1_rev   = rv1;
    out_ready  = ordy;
  endtask

  // One clock: check grants before the edge, advance the model, check the slot after.
  task automatic runCycle(input string tag);
    bit acc_en, win, e0, e1, drain;
    #2;
    acc_en = !m_full || out_ready;
    if (req0_valid && req1_valid) begin
`ifdef REV_RR_EN
      win = !m_last;
`else
      win = 1'b0;
`endif
    end else begin
      win = !req0_valid;
    end
    e0 = !rst && acc_en && req0_valid && !win;
    e1 = !rst && acc_en && req1_valid && win;
    checkOutput({tag, "/req0_ready"}, req0_ready, e0);
    checkOutput({tag, "/req1_ready"}, req1_ready, e1);

    @(posedge clk);
    if (rst) begin
      m_full = 0; m_data = '0; m_id = 0; m_cnt = 0; m_last = 1;
    end else begin
      drain = m_full && out_ready;
      if (drain && m_cnt < CNT_MAX) m_cnt++;
      if (e0 || e1) begin
        m_full = 1;
        m_id   = e1;
        m_last = e1;
        m_data = e1 ? expectResult(req1_data, req1_rev) : expectResult(req0_data, req0_rev);
      end else if (drain) begin
        m_full = 0;
      end
    end
    took0 = e0;
    took1 = e1;

    #1;
    checkOutput({tag, "/out_valid"}, out_valid, m_full);
    checkOutput({tag, "/out_data"},  out_data,  m_data);
    checkOutput({tag, "/out_id"},    out_id,    m_id);
    checkOutput({tag, "/done_cnt"},  done_cnt,  m_cnt);
  endtask

  bit [1:0]  rr_ids [4];
  bit        v0, v1, rv0, rv1, rr_rst, ordy;
  bit [15:0] d0, d1;

  initial begin
    // Reset state
    applyStimulus(1, 0, '0, 0, 0, '0, 0, 0);
    runCycle("reset");
    runCycle("reset");
    checkOutput("reset_data", out_data, 16'h0000);

    // Requester 0, reversed
    applyStimulus(0, 1, 16'h0001, 1, 0, '0, 0, 1);
    runCycle("rev0");
    checkOutput("rev0_data", out_data, 16'h8000);
    checkOutput("rev0_id", out_id, 1'b0);
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 1);
    runCycle("rev0_drain");
    checkOutput("rev0_cnt", done_cnt, 4'd1);

    // Requester 1, pass-through
    applyStimulus(0, 0, '0, 0, 1, 16'h00F0, 0, 1);
    runCycle("pass1");
    checkOutput("pass1_data", out_data, 16'h00F0);
    checkOutput("pass1_id", out_id, 1'b1);

    // Continuous contention for four cycles
`ifdef REV_RR_EN
    rr_ids = '{0, 1, 0, 1};
`else
    rr_ids = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 1, 16'($urandom), 1'($urandom), 1, 16'($urandom), 1'($urandom), 1);
      runCycle("contend");
      checkOutput("contend_id", out_id, rr_ids[i]);
    end
    applyStimulus(0, 0, '0, 0, 0, '0, 0, 1);
    runCycle("contend_drain");

    // Backpressure: slot full and consumer stalled
    applyStimulus(0, 1, 16'h1234, 0, 0, '0, 0, 1);
    runCycle("bp_fill");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 16'hABCD, 0, 0, '0, 0, 0);
      runCycle("bp_stall");
      checkOutput("bp_stable", out_data, 16'h1234);
    end
    applyStimulus(0, 1, 16'hABCD, 0, 0, '0, 0, 1);
    runCycle("bp_release");
    checkOutput("bp_valid", out_valid, 1'b1);
    checkOutput("bp_new_data", out_data, 16'hABCD);

    // Counter saturation
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 16'($urandom), 1'($urandom), 0, '0, 0, 1);
      runCycle("sat");
    end
    checkOutput("sat_cnt", done_cnt, 4'hF);
    runCycle("sat_hold");
    checkOutput("sat_hold_cnt", done_cnt, 4'hF);

    // Reset while holding a stalled result
    applyStimulus(0, 1, 16'h5A5A, 1, 0, '0, 0, 0);
    runCycle("pre_rst");
    applyStimulus(1, 1, 16'h0F0F, 1, 1, 16'hF0F0, 0, 1);
    runCycle("rst_hold");
    checkOutput("rst_hold_valid", out_valid, 1'b0);
    checkOutput("rst_hold_cnt", done_cnt, 4'h0);
    applyStimulus(0, 1, 16'h0F0F, 1, 1, 16'hF0F0, 0, 1);
    runCycle("post_rst");
    checkOutput("post_rst_id", out_id, 1'b0);

    // Random traffic; requesters hold their operand until granted
    v0 = 0; v1 = 0; d0 = '0; d1 = '0; rv0 = 0; rv1 = 0;
    took0 = 1; took1 = 1;
    for (int i = 0; i < 400; i++) begin
      if (took0 || !v0) begin
        v0 = $urandom_range(0, 2) != 0; d0 = 16'($urandom); rv0 = 1'($urandom);
      end
      if (took1 || !v1) begin
        v1 = $urandom_range(0, 2) != 0; d1 = 16'($urandom); rv1 = 1'($urandom);
      end
      ordy   = $urandom_range(0, 3) != 0;
      rr_rst = $urandom_range(0, 49) == 0;
      applyStimulus(rr_rst, v0, d0, rv0, v1, d1, rv1, ordy);
      runCycle("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_rev_share_ctrl
